// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - per-frame layer-fetch request sequencer, pipe 0
// Walks pixels in raster order and, for each pixel, every enabled layer from lowest to highest.
module layer_scheduler #(
  parameter int LAYERS    = 32,
  parameter int LAYER_W   = 5,
  parameter int PIX_W     = 19,
  parameter int PIX_COUNT = 307200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [LAYERS-1:0]  layer_en,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [LAYER_W-1:0] req_layer,
  output logic [PIX_W-1:0]   req_pixel,
  output logic               req_last,
  output logic               pixel_done,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIX_COUNT - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t             r_state;
  logic [LAYERS-1:0]  r_mask;
  logic               r_req_valid;
  logic [LAYER_W-1:0] r_req_layer;
  logic [PIX_W-1:0]   r_req_pixel;
  logic               r_pixel_done;
  logic               r_frame_done;
  logic               r_busy;

  logic               w_found_next;
  logic [LAYER_W-1:0] w_next_layer;
  logic [LAYER_W-1:0] w_start_layer;
  logic [LAYER_W-1:0] w_mask_first;
  logic               w_handshake;

  // Downward scans so the last hit wins, giving the lowest qualifying index.
  always_comb begin
    w_found_next  = 1'b0;
    w_next_layer  = '0;
    w_start_layer = '0;
    w_mask_first  = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_req_layer))) begin
        w_found_next = 1'b1;
        w_next_layer = LAYER_W'(i);
      end
      if (layer_en[i]) w_start_layer = LAYER_W'(i);
      if (r_mask[i])   w_mask_first  = LAYER_W'(i);
    end
  end

  assign w_handshake = r_req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_req_valid  <= 1'b0;
      r_req_layer  <= '0;
      r_req_pixel  <= '0;
      r_pixel_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pixel_done <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_mask <= layer_en;
            if (|layer_en) begin
              r_state     <= S_ISSUE;
              r_req_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_req_pixel <= '0;
              r_req_layer <= w_start_layer;
            end else begin
              r_frame_done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_handshake) begin
            if (w_found_next) begin
              r_req_layer <= w_next_layer;
            end else if (r_req_pixel != LAST_PIX) begin
              r_req_pixel  <= r_req_pixel + 1'b1;
              r_req_layer  <= w_mask_first;
              r_pixel_done <= 1'b1;
            end else begin
              r_state      <= S_IDLE;
              r_req_valid  <= 1'b0;
              r_busy       <= 1'b0;
              r_req_layer  <= '0;
              r_req_pixel  <= '0;
              r_pixel_done <= 1'b1;
              r_frame_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_valid  = r_req_valid;
  assign req_layer  = r_req_layer;
  assign req_pixel  = r_req_pixel;
  assign req_last   = r_req_valid & ~w_found_next;
  assign pixel_done = r_pixel_done;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - directed bench for layer_scheduler with a 4-pixel frame
module tb_layer_scheduler;

  localparam int PIXC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] layer_en = '0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [4:0]  req_layer;
  logic [18:0] req_pixel;
  logic        req_last;
  logic        pixel_done;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  layer_scheduler #(.LAYERS(32), .LAYER_W(5), .PIX_W(19), .PIX_COUNT(PIXC)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .layer_en(layer_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_layer(req_layer),
    .req_pixel(req_pixel), .req_last(req_last), .pixel_done(pixel_done),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({req_valid, busy, req_last, pixel_done, frame_done, req_layer, req_pixel} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v%b b%b l%b pd%b fd%b layer%0d pix%0d, want all 0",
               req_valid, busy, req_last, pixel_done, frame_done, req_layer, req_pixel);
    end
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({req_valid, busy, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_idle: got v%b b%b fd%b, want 000", req_valid, busy, frame_done);
    end
  endtask

  task automatic test_single_layer();
    frame_start = 1'b1; layer_en = 32'h0000_0001; req_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int p = 0; p < PIXC; p++) begin
      n_checks++;
      if ({req_valid, busy, req_last, pixel_done, frame_done} !== {1'b1, 1'b1, 1'b1, p != 0, 1'b0}) begin
        n_errors++;
        $display("FAIL single_flags p%0d: got v%b b%b l%b pd%b fd%b, want 1 1 1 %0d 0",
                 p, req_valid, busy, req_last, pixel_done, frame_done, p != 0);
      end
      n_checks++;
      if (req_layer !== 5'd0 || req_pixel !== 19'(p)) begin
        n_errors++;
        $display("FAIL single_req p%0d: got layer %0d pixel %0d, want layer 0 pixel %0d", p, req_layer, req_pixel, p);
      end
      tick();
    end
    n_checks++;
    if ({req_valid, busy, pixel_done, frame_done} !== 4'b0011) begin
      n_errors++;
      $display("FAIL single_end: got v%b b%b pd%b fd%b, want 0 0 1 1", req_valid, busy, pixel_done, frame_done);
    end
    tick();
    n_checks++;
    if ({req_valid, pixel_done, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL single_done_pulse: got v%b pd%b fd%b, want 000", req_valid, pixel_done, frame_done);
    end
  endtask

  task automatic test_sparse_mask();
    logic [4:0] lay [3];
    lay[0] = 5'd0; lay[1] = 5'd2; lay[2] = 5'd31;
    frame_start = 1'b1; layer_en = 32'h8000_0005; req_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 3 * PIXC; k++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_layer !== lay[k % 3] || req_pixel !== 19'(k / 3) ||
          req_last !== (k % 3 == 2) || pixel_done !== (k > 0 && k % 3 == 0)) begin
        n_errors++;
        $display("FAIL sparse step %0d: got v%b layer %0d pix %0d last %b pd %b, want 1 %0d %0d %b %b",
                 k, req_valid, req_layer, req_pixel, req_last, pixel_done,
                 lay[k % 3], k / 3, k % 3 == 2, k > 0 && k % 3 == 0);
      end
      tick();
    end
    n_checks++;
    if ({req_valid, busy, pixel_done, frame_done} !== 4'b0011) begin
      n_errors++;
      $display("FAIL sparse_end: got v%b b%b pd%b fd%b, want 0 0 1 1", req_valid, busy, pixel_done, frame_done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    frame_start = 1'b1; layer_en = 32'h0000_000E; req_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    req_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (req_valid !== 1'b1 || req_layer !== 5'd2 || req_pixel !== 19'd0 || req_last !== 1'b0 || pixel_done !== 1'b0) begin
        n_errors++;
        $display("FAIL stall cycle %0d: got v%b layer %0d pix %0d last %b pd %b, want 1 2 0 0 0",
                 s, req_valid, req_layer, req_pixel, req_last, pixel_done);
      end
    end
    req_ready = 1'b1;
    for (int k = 1; k < 3 * PIXC; k++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_layer !== 5'(k % 3 + 1) || req_pixel !== 19'(k / 3) || req_last !== (k % 3 == 2)) begin
        n_errors++;
        $display("FAIL resume step %0d: got v%b layer %0d pix %0d last %b, want 1 %0d %0d %b",
                 k, req_valid, req_layer, req_pixel, req_last, k % 3 + 1, k / 3, k % 3 == 2);
      end
      tick();
    end
    n_checks++;
    if ({req_valid, frame_done} !== 2'b01) begin
      n_errors++;
      $display("FAIL backpressure_end: got v%b fd%b, want 0 1", req_valid, frame_done);
    end
    tick();
  endtask

  task automatic test_empty_mask();
    frame_start = 1'b1; layer_en = 32'h0;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if ({req_valid, busy, pixel_done, frame_done} !== 4'b0001) begin
      n_errors++;
      $display("FAIL empty_start: got v%b b%b pd%b fd%b, want 0 0 0 1", req_valid, busy, pixel_done, frame_done);
    end
    tick();
    n_checks++;
    if ({req_valid, busy, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL empty_after: got v%b b%b fd%b, want 000", req_valid, busy, frame_done);
    end
  endtask

  task automatic test_ignored_inputs();
    bit seen;
    frame_start = 1'b1; layer_en = 32'h0000_0001; req_ready = 1'b1;
    tick();
    frame_start = 1'b1; layer_en = 32'hFFFF_FFFF;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (req_pixel !== 19'd1 || req_layer !== 5'd0 || req_last !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ignore_busy: got pix %0d layer %0d last %b busy %b, want 1 0 1 1", req_pixel, req_layer, req_last, busy);
    end
    tick();
    frame_start = 1'b1; layer_en = 32'h0000_0003;
    tick();
    n_checks++;
    if (req_pixel !== 19'd3 || req_last !== 1'b1) begin
      n_errors++;
      $display("FAIL ignore_final_setup: got pix %0d last %b, want 3 1", req_pixel, req_last);
    end
    tick();
    n_checks++;
    if ({req_valid, busy, frame_done} !== 3'b001) begin
      n_errors++;
      $display("FAIL ignore_final_hs: got v%b b%b fd%b, want 0 0 1", req_valid, busy, frame_done);
    end
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || busy !== 1'b1 || req_pixel !== 19'd0 || req_layer !== 5'd0 || req_last !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_on_done: got v%b b%b pix %0d layer %0d last %b, want 1 1 0 0 0",
               req_valid, busy, req_pixel, req_layer, req_last);
    end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      seen = frame_done;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL restart_drain: got no frame_done within 30 cycles, want frame_done");
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit seen;
    frame_start = 1'b1; layer_en = 32'h0000_0007; req_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (req_pixel !== 19'd1 || req_layer !== 5'd2) begin
      n_errors++;
      $display("FAIL reset_setup: got pix %0d layer %0d, want 1 2", req_pixel, req_layer);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_valid, busy, req_last, pixel_done, frame_done, req_layer, req_pixel} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got v%b b%b l%b pd%b fd%b layer %0d pix %0d, want all 0",
               req_valid, busy, req_last, pixel_done, frame_done, req_layer, req_pixel);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({req_valid, busy, frame_done, pixel_done} !== 4'b0000) begin
      n_errors++;
      $display("FAIL post_reset_idle: got v%b b%b fd%b pd%b, want 0000", req_valid, busy, frame_done, pixel_done);
    end
    frame_start = 1'b1; layer_en = 32'h0000_0004;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1 || req_pixel !== 19'd0 || req_layer !== 5'd2 || req_last !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_start: got v%b pix %0d layer %0d last %b, want 1 0 2 1", req_valid, req_pixel, req_layer, req_last);
    end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick();
      seen = frame_done;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL post_reset_drain: got no frame_done within 30 cycles, want frame_done");
    end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_sparse_mask();
    test_backpressure();
    test_empty_mask();
    test_ignored_inputs();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
